// File: rtl/ucode_sequencer.sv
// Micro-program sequencer around the next-address ROM: walks one opcode's microcode chain.
// Optional trace counters are built only when UCODE_TRACE_EN is defined.
module ucode_sequencer #(
  parameter int unsigned ADR_W    = 9,
  parameter int unsigned MAX_UOPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bc_valid,
  input  logic [7:0]       bc_opcode,
  output logic             bc_ready,
  output logic [ADR_W-1:0] rom_adr,
  input  logic [ADR_W-1:0] rom_next,
  output logic             uop_valid,
  output logic [ADR_W-1:0] uop_adr,
  output logic             uop_last,
  input  logic             uop_ready,
  output logic             err,
  output logic [ADR_W-1:0] err_adr,
  input  logic             err_clr,
  output logic [31:0]      cnt_uops,
  output logic [31:0]      cnt_bcs
);

  typedef enum logic [1:0] {StIdle, StIssue, StError} state_e;

  state_e           state_q, state_d;
  logic [ADR_W-1:0] upc_q, upc_d;
  logic [ADR_W-1:0] err_adr_q, err_adr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             next_end, next_bad, uop_fire;

  assign next_end = (rom_next == '0);
  // All-ones is the ROM default; anything below 256 would re-enter opcode space.
  assign next_bad = (&rom_next) || (rom_next[ADR_W-1:8] == '0);
  assign uop_fire = (state_q == StIssue) && uop_ready;

  assign rom_adr = upc_q;
  assign uop_adr = upc_q;
  assign err_adr = err_adr_q;

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    cnt_d     = cnt_q;
    err_adr_d = err_adr_q;
    bc_ready  = 1'b0;
    uop_valid = 1'b0;
    uop_last  = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        bc_ready = 1'b1;
        if (bc_valid) begin
          upc_d   = {{(ADR_W-8){1'b0}}, bc_opcode};
          cnt_d   = 8'd1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        uop_valid = 1'b1;
        uop_last  = next_end;
        if (uop_fire) begin
          if (next_end) begin
            state_d = StIdle;
          end else if (next_bad || (cnt_q == 8'(MAX_UOPS))) begin
            state_d   = StError;
            err_adr_d = upc_q;
          end else begin
            upc_d = rom_next;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StError: begin
        err = 1'b1;
        if (err_clr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      upc_q     <= '0;
      cnt_q     <= '0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      cnt_q     <= cnt_d;
      err_adr_q <= err_adr_d;
    end
  end

`ifdef UCODE_TRACE_EN
  logic [31:0] cnt_uops_q, cnt_bcs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_uops_q <= '0;
      cnt_bcs_q  <= '0;
    end else if (uop_fire) begin
      cnt_uops_q <= cnt_uops_q + 32'd1;
      if (next_end) cnt_bcs_q <= cnt_bcs_q + 32'd1;
    end
  end

  assign cnt_uops = cnt_uops_q;
  assign cnt_bcs  = cnt_bcs_q;
`else
  assign cnt_uops = '0;
  assign cnt_bcs  = '0;
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: directed scenarios plus random ROM contents,
// checked against a chain-walking reference model.
module tb_ucode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bc_valid, uop_ready, err_clr;
  logic [7:0] bc_opcode;
  logic       bc_ready, uop_valid, uop_last, err;
  logic [8:0] rom_adr, rom_next, uop_adr, err_adr;
  logic [31:0] cnt_uops, cnt_bcs;

  logic       bc_valid2, uop_ready2, err_clr2;
  logic [7:0] bc_opcode2;
  logic       bc_ready2, uop_valid2, uop_last2, err2;
  logic [8:0] rom_adr2, rom_next2, uop_adr2, err_adr2;
  logic [31:0] cnt_uops2, cnt_bcs2;

  logic [8:0] rom [512];

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_adr [$];
  bit         exp_last [$];
  bit         exp_err;
  logic [8:0] exp_err_adr;
  logic [8:0] hold_err_adr = '0;
  int         exp_uops = 0;
  int         exp_bcs = 0;

  always #5 clk = ~clk;

  assign rom_next  = rom[rom_adr];
  assign rom_next2 = rom[rom_adr2];

  ucode_sequencer #(.ADR_W(9), .MAX_UOPS(16)) dut (
    .clk(clk), .rst_n(rst_n), .bc_valid(bc_valid), .bc_opcode(bc_opcode), .bc_ready(bc_ready),
    .rom_adr(rom_adr), .rom_next(rom_next), .uop_valid(uop_valid), .uop_adr(uop_adr),
    .uop_last(uop_last), .uop_ready(uop_ready), .err(err), .err_adr(err_adr),
    .err_clr(err_clr), .cnt_uops(cnt_uops), .cnt_bcs(cnt_bcs)
  );

  ucode_sequencer #(.ADR_W(9), .MAX_UOPS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bc_valid(bc_valid2), .bc_opcode(bc_opcode2),
    .bc_ready(bc_ready2), .rom_adr(rom_adr2), .rom_next(rom_next2), .uop_valid(uop_valid2),
    .uop_adr(uop_adr2), .uop_last(uop_last2), .uop_ready(uop_ready2), .err(err2),
    .err_adr(err_adr2), .err_clr(err_clr2), .cnt_uops(cnt_uops2), .cnt_bcs(cnt_bcs2)
  );

  // Reference: follow the chain from the opcode, stopping at end, bad link or uop budget.
  function automatic void build_model(input logic [7:0] op, input int maxu);
    logic [8:0] a, nx;
    exp_adr.delete();
    exp_last.delete();
    exp_err = 1'b0;
    a = {1'b0, op};
    for (int c = 1; c <= 300; c++) begin
      exp_adr.push_back(a);
      nx = rom[a];
      if (nx == 9'd0) begin
        exp_last.push_back(1'b1);
        break;
      end
      exp_last.push_back(1'b0);
      if (nx == 9'h1FF || nx < 9'd256 || c == maxu) begin
        exp_err     = 1'b1;
        exp_err_adr = a;
        break;
      end
      a = nx;
    end
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 9'h1FF;
  endtask

  task automatic randomize_rom();
    int r;
    for (int i = 0; i < 512; i++) begin
      r = $urandom_range(99);
      if (r < 15)      rom[i] = 9'd0;
      else if (r < 18) rom[i] = 9'h1FF;
      else if (r < 21) rom[i] = 9'($urandom_range(255, 1));
      else             rom[i] = 9'h100 + 9'($urandom_range(254));
    end
  endtask

  // Issue one opcode and follow it to completion or trap; stall_idx holds ready low 3 cycles.
  task automatic run_bc(input logic [7:0] op, input int ready_pct, input int stall_idx,
                        input bit rand_clr);
    int idx = 0, cyc = 0, stalls = 0;
    int want_u, want_b;
    build_model(op, 16);
    tests++;
    if (bc_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready op=%h got=%b want=1", op, bc_ready);
    end
    bc_valid  = 1'b1;
    bc_opcode = op;
    @(posedge clk); #1;
    bc_valid  = 1'b0;
    bc_opcode = 8'($urandom);
    while (idx < exp_adr.size() && cyc < 500) begin
      uop_ready = ($urandom_range(99) < ready_pct);
      if (idx == stall_idx && stalls < 3) begin
        uop_ready = 1'b0;
        stalls++;
      end
      err_clr = rand_clr ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      tests++;
      if (uop_valid !== 1'b1 || uop_adr !== exp_adr[idx] || uop_last !== exp_last[idx] ||
          bc_ready !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL uop op=%h idx=%0d got v=%b a=%h l=%b r=%b e=%b want v=1 a=%h l=%b r=0 e=0",
                 op, idx, uop_valid, uop_adr, uop_last, bc_ready, err, exp_adr[idx],
                 exp_last[idx]);
      end
      if (uop_ready) begin
        idx++;
        exp_uops++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    uop_ready = 1'b0;
    err_clr   = 1'b0;
    if (cyc >= 500) begin
      tests++;
      fails++;
      $display("FAIL timeout op=%h got idx=%0d want %0d", op, idx, exp_adr.size());
    end
    if (exp_err) hold_err_adr = exp_err_adr;
    else exp_bcs++;
    tests++;
    if (bc_ready !== !exp_err || err !== exp_err || uop_valid !== 1'b0 ||
        err_adr !== hold_err_adr) begin
      fails++;
      $display("FAIL end op=%h got r=%b e=%b v=%b ea=%h want r=%b e=%b v=0 ea=%h", op, bc_ready,
               err, uop_valid, err_adr, !exp_err, exp_err, hold_err_adr);
    end
`ifdef UCODE_TRACE_EN
    want_u = exp_uops;
    want_b = exp_bcs;
`else
    want_u = 0;
    want_b = 0;
`endif
    tests++;
    if (cnt_uops !== 32'(want_u) || cnt_bcs !== 32'(want_b)) begin
      fails++;
      $display("FAIL counters op=%h got u=%0d b=%0d want u=%0d b=%0d", op, cnt_uops, cnt_bcs,
               want_u, want_b);
    end
    if (exp_err) begin
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (err !== 1'b1 || bc_ready !== 1'b0) begin
        fails++;
        $display("FAIL err_sticky got e=%b r=%b want e=1 r=0", err, bc_ready);
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      tests++;
      if (err !== 1'b0 || bc_ready !== 1'b1 || err_adr !== hold_err_adr) begin
        fails++;
        $display("FAIL err_clr got e=%b r=%b ea=%h want e=0 r=1 ea=%h", err, bc_ready, err_adr,
                 hold_err_adr);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bc_ready !== 1'b1 || uop_valid !== 1'b0 || err !== 1'b0 || err_adr !== 9'd0 ||
        rom_adr !== 9'd0 || cnt_uops !== 32'd0 || cnt_bcs !== 32'd0 || bc_ready2 !== 1'b1 ||
        uop_valid2 !== 1'b0 || err2 !== 1'b0 || cnt_uops2 !== 32'd0 || cnt_bcs2 !== 32'd0) begin
      fails++;
      $display("FAIL reset got r=%b v=%b e=%b ea=%h ra=%h cu=%0d cb=%0d want r=1 v=0 e=0 ea=0 ra=0",
               bc_ready, uop_valid, err, err_adr, rom_adr, cnt_uops, cnt_bcs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_chain();
    clear_rom();
    rom[9'h059] = 9'h100;
    rom[9'h100] = 9'h101;
    rom[9'h101] = 9'h000;
    run_bc(8'h59, 100, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    rom[9'h000] = 9'h000;
    rom[9'h00B] = 9'h10C;
    rom[9'h10C] = 9'h000;
    run_bc(8'h00, 100, -1, 1'b0);
    run_bc(8'h0B, 100, -1, 1'b0);
  endtask

  task automatic test_stall();
    rom[9'h05C] = 9'h102;
    rom[9'h102] = 9'h103;
    rom[9'h103] = 9'h000;
    run_bc(8'h5C, 100, 1, 1'b0);
  endtask

  task automatic test_illegal();
    rom[9'h101] = 9'h1FF;
    run_bc(8'h59, 100, -1, 1'b0);
    rom[9'h101] = 9'h000;
    rom[9'h100] = 9'h020;
    run_bc(8'h59, 100, -1, 1'b0);
    rom[9'h100] = 9'h101;
    run_bc(8'h0B, 100, -1, 1'b0);
  endtask

  task automatic test_runaway_small();
    logic [8:0] want [2];
    want[0] = 9'h059;
    want[1] = 9'h100;
    bc_valid2  = 1'b1;
    bc_opcode2 = 8'h59;
    uop_ready2 = 1'b1;
    @(posedge clk); #1;
    bc_valid2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (uop_valid2 !== 1'b1 || uop_adr2 !== want[i] || uop_last2 !== 1'b0) begin
        fails++;
        $display("FAIL runaway_uop idx=%0d got v=%b a=%h l=%b want v=1 a=%h l=0", i, uop_valid2,
                 uop_adr2, uop_last2, want[i]);
      end
      @(posedge clk); #1;
    end
    repeat (3) begin
      tests++;
      if (err2 !== 1'b1 || err_adr2 !== 9'h100 || uop_valid2 !== 1'b0 || bc_ready2 !== 1'b0) begin
        fails++;
        $display("FAIL runaway_trap got e=%b ea=%h v=%b r=%b want e=1 ea=100 v=0 r=0", err2,
                 err_adr2, uop_valid2, bc_ready2);
      end
      @(posedge clk); #1;
    end
    uop_ready2 = 1'b0;
    err_clr2   = 1'b1;
    @(posedge clk); #1;
    err_clr2 = 1'b0;
    tests++;
    if (err2 !== 1'b0 || bc_ready2 !== 1'b1 || err_adr2 !== 9'h100) begin
      fails++;
      $display("FAIL runaway_clr got e=%b r=%b ea=%h want e=0 r=1 ea=100", err2, bc_ready2,
               err_adr2);
    end
  endtask

  task automatic test_reset_midchain();
    clear_rom();
    rom[9'h059] = 9'h100;
    rom[9'h100] = 9'h101;
    rom[9'h101] = 9'h000;
    bc_valid  = 1'b1;
    bc_opcode = 8'h59;
    uop_ready = 1'b1;
    @(posedge clk); #1;
    bc_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (uop_valid !== 1'b1 || uop_adr !== 9'h100) begin
      fails++;
      $display("FAIL midchain_pre got v=%b a=%h want v=1 a=100", uop_valid, uop_adr);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_uops = 0;
    exp_bcs = 0;
    hold_err_adr = '0;
    tests++;
    if (uop_valid !== 1'b0 || bc_ready !== 1'b1 || err_adr !== 9'd0 || cnt_uops !== 32'd0 ||
        cnt_bcs !== 32'd0) begin
      fails++;
      $display("FAIL midchain_reset got v=%b r=%b ea=%h cu=%0d cb=%0d want v=0 r=1 ea=0 cu=0 cb=0",
               uop_valid, bc_ready, err_adr, cnt_uops, cnt_bcs);
    end
    uop_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_bc(8'h59, 100, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 200; it++) begin
      if (it % 10 == 0) randomize_rom();
      run_bc(8'($urandom), int'($urandom_range(100, 40)), -1, 1'b1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bc_valid = 1'b0;  bc_opcode = '0;  uop_ready = 1'b0;  err_clr = 1'b0;
    bc_valid2 = 1'b0; bc_opcode2 = '0; uop_ready2 = 1'b0; err_clr2 = 1'b0;
    clear_rom();
    test_reset();
    test_basic_chain();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_runaway_small();
    test_random();
    test_reset_midchain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
